// File: rtl/tpg_timing_ctrl.sv
// ----------------------------------------------------------------------------
// tpg_timing_ctrl
//
// Run/timing controller in front of the test pattern generator.
//
// Timing registers are written into a shadow set. A commit copies the shadow
// set into the active set, which drives the generator:
//   - in IDLE the copy happens on the edge that accepts the commit;
//   - while running (RUN or STOPPING) the copy waits for the next sof, so the
//     generator never sees a mode change in the middle of a frame.
// Generator enable is sequenced by start/stop and an optional frame limit.
// Once stopping has been requested, run_en is only dropped on a frame
// boundary (sof).
//
// Optional feature (macro TPG_TIMING_CHECK_EN): a commit is rejected with a
// one-cycle cfg_err pulse when the shadow timing is not ordered as
//   start < end <= total, for the HS, HACT, VS and VACT windows.
// Without the macro every commit is accepted and cfg_err stays 0.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cfg_wr/addr/wdata register write port (0-9 timing shadow, 10 FRAME_LIMIT)
//   cfg_commit        request shadow->active transfer
//   start, stop       run control pulses
//   sof               start-of-frame pulse from the generator
//   run_en            generator enable
//   tHS_START..tV_END active timing set
//   mode_valid        a mode has been applied since reset
//   mode_applied      one-cycle pulse when the active set changes
//   commit_pending    commit accepted, waiting for sof
//   cfg_err           one-cycle pulse, commit rejected
//   frame_cnt         frames started since last start (saturating)
// ----------------------------------------------------------------------------
module tpg_timing_ctrl #(
    parameter int H_BITS = 12,
    parameter int V_BITS = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_wr,
    input  logic [3:0]        cfg_addr,
    input  logic [15:0]       cfg_wdata,
    input  logic              cfg_commit,
    input  logic              start,
    input  logic              stop,
    input  logic              sof,
    output logic              run_en,
    output logic [H_BITS-1:0] tHS_START,
    output logic [H_BITS-1:0] tHS_END,
    output logic [H_BITS-1:0] tHACT_START,
    output logic [H_BITS-1:0] tHACT_END,
    output logic [H_BITS-1:0] tH_END,
    output logic [V_BITS-1:0] tVS_START,
    output logic [V_BITS-1:0] tVS_END,
    output logic [V_BITS-1:0] tVACT_START,
    output logic [V_BITS-1:0] tVACT_END,
    output logic [V_BITS-1:0] tV_END,
    output logic              mode_valid,
    output logic              mode_applied,
    output logic              commit_pending,
    output logic              cfg_err,
    output logic [CNT_W-1:0]  frame_cnt
);

    // Index order inside the H and V register arrays: SYNC start, SYNC end,
    // ACTIVE start, ACTIVE end, total end.
    localparam int IDX_S_START = 0;
    localparam int IDX_S_END   = 1;
    localparam int IDX_A_START = 2;
    localparam int IDX_A_END   = 3;
    localparam int IDX_END     = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    state_t             r_state;
    logic [H_BITS-1:0]  r_sh_h  [5];
    logic [V_BITS-1:0]  r_sh_v  [5];
    logic [H_BITS-1:0]  r_act_h [5];
    logic [V_BITS-1:0]  r_act_v [5];
    logic [CNT_W-1:0]   r_frame_limit;
    logic [CNT_W-1:0]   r_frame_cnt;
    logic               r_run_en;
    logic               r_mode_valid;
    logic               r_mode_applied;
    logic               r_pending;
    logic               r_cfg_err;

    logic               w_timing_ok;
    logic               w_commit_ok;
    logic               w_apply;
    logic [3:0]         w_vaddr;
    logic [CNT_W:0]     w_cnt_inc;
    logic               w_limit_hit;

    // High write-data bits beyond the register widths are don't-care.
    logic               w_unused;
    assign w_unused = &{1'b0, cfg_wdata};

`ifdef TPG_TIMING_CHECK_EN
    function automatic logic f_h_ok(input logic [H_BITS-1:0] s,
                                    input logic [H_BITS-1:0] e,
                                    input logic [H_BITS-1:0] tot);
        return (s < e) && (e <= tot);
    endfunction

    function automatic logic f_v_ok(input logic [V_BITS-1:0] s,
                                    input logic [V_BITS-1:0] e,
                                    input logic [V_BITS-1:0] tot);
        return (s < e) && (e <= tot);
    endfunction

    assign w_timing_ok =
        f_h_ok(r_sh_h[IDX_S_START], r_sh_h[IDX_S_END], r_sh_h[IDX_END]) &&
        f_h_ok(r_sh_h[IDX_A_START], r_sh_h[IDX_A_END], r_sh_h[IDX_END]) &&
        f_v_ok(r_sh_v[IDX_S_START], r_sh_v[IDX_S_END], r_sh_v[IDX_END]) &&
        f_v_ok(r_sh_v[IDX_A_START], r_sh_v[IDX_A_END], r_sh_v[IDX_END]);
`else
    assign w_timing_ok = 1'b1;
`endif

    assign w_commit_ok = cfg_commit && w_timing_ok;

    // In IDLE an accepted commit applies at once. While running, the copy is
    // taken at sof if a commit is pending or arrives in that very cycle.
    assign w_apply = (r_state == ST_IDLE) ? w_commit_ok
                                          : (sof && (r_pending || w_commit_ok));

    assign w_vaddr     = cfg_addr - 4'd5;
    assign w_cnt_inc   = {1'b0, r_frame_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign w_limit_hit = (r_frame_limit != '0) &&
                         (w_cnt_inc == {1'b0, r_frame_limit});

    // Shadow registers and frame limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) begin
                r_sh_h[i] <= '0;
                r_sh_v[i] <= '0;
            end
            r_frame_limit <= '0;
        end else if (cfg_wr) begin
            if (cfg_addr < 4'd5) begin
                r_sh_h[cfg_addr[2:0]] <= cfg_wdata[H_BITS-1:0];
            end else if (cfg_addr < 4'd10) begin
                r_sh_v[w_vaddr[2:0]] <= cfg_wdata[V_BITS-1:0];
            end else if (cfg_addr == 4'd10) begin
                r_frame_limit <= cfg_wdata[CNT_W-1:0];
            end
        end
    end

    // Active set and mode status. The shadow value in effect before this edge
    // is what gets copied, so a same-cycle write is not part of the apply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) begin
                r_act_h[i] <= '0;
                r_act_v[i] <= '0;
            end
            r_mode_valid   <= 1'b0;
            r_mode_applied <= 1'b0;
            r_cfg_err      <= 1'b0;
        end else begin
            if (w_apply) begin
                for (int i = 0; i < 5; i++) begin
                    r_act_h[i] <= r_sh_h[i];
                    r_act_v[i] <= r_sh_v[i];
                end
                r_mode_valid <= 1'b1;
            end
            r_mode_applied <= w_apply;
            r_cfg_err      <= cfg_commit && !w_timing_ok;
        end
    end

    // Run control FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_run_en    <= 1'b0;
            r_pending   <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_run_en  <= 1'b0;
                    r_pending <= 1'b0;
                    // stop beats start when both arrive together
                    if (start && !stop && r_mode_valid) begin
                        r_state     <= ST_RUN;
                        r_run_en    <= 1'b1;
                        r_frame_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (sof) begin
                        r_pending <= 1'b0;
                        if (!w_cnt_inc[CNT_W]) begin
                            r_frame_cnt <= w_cnt_inc[CNT_W-1:0];
                        end
                    end else if (w_commit_ok) begin
                        r_pending <= 1'b1;
                    end
                    if (stop || (sof && w_limit_hit)) begin
                        r_state <= ST_STOPPING;
                    end
                end
                ST_STOPPING: begin
                    if (sof) begin
                        r_pending <= 1'b0;
                        r_run_en  <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else if (w_commit_ok) begin
                        r_pending <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_run_en  <= 1'b0;
                    r_pending <= 1'b0;
                end
            endcase
        end
    end

    assign run_en         = r_run_en;
    assign mode_valid     = r_mode_valid;
    assign mode_applied   = r_mode_applied;
    assign commit_pending = r_pending;
    assign cfg_err        = r_cfg_err;
    assign frame_cnt      = r_frame_cnt;

    assign tHS_START   = r_act_h[IDX_S_START];
    assign tHS_END     = r_act_h[IDX_S_END];
    assign tHACT_START = r_act_h[IDX_A_START];
    assign tHACT_END   = r_act_h[IDX_A_END];
    assign tH_END      = r_act_h[IDX_END];
    assign tVS_START   = r_act_v[IDX_S_START];
    assign tVS_END     = r_act_v[IDX_S_END];
    assign tVACT_START = r_act_v[IDX_A_START];
    assign tVACT_END   = r_act_v[IDX_A_END];
    assign tV_END      = r_act_v[IDX_END];

endmodule

// File: tb/tb_tpg_timing_ctrl.sv
// ----------------------------------------------------------------------------
// tb_tpg_timing_ctrl
//
// Directed testbench for tpg_timing_ctrl. Inputs are driven 1 ns after the
// rising edge and outputs are sampled at the same point, so every sample shows
// the state produced by the edge that consumed the previous inputs.
// Define TPG_TIMING_CHECK_EN for both bench and RTL to cover the timing check.
// ----------------------------------------------------------------------------
module tb_tpg_timing_ctrl;

    localparam int H_BITS = 12;
    localparam int V_BITS = 12;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_wr = 1'b0;
    logic [3:0]        cfg_addr = '0;
    logic [15:0]       cfg_wdata = '0;
    logic              cfg_commit = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              sof = 1'b0;
    logic              run_en;
    logic [H_BITS-1:0] tHS_START, tHS_END, tHACT_START, tHACT_END, tH_END;
    logic [V_BITS-1:0] tVS_START, tVS_END, tVACT_START, tVACT_END, tV_END;
    logic              mode_valid, mode_applied, commit_pending, cfg_err;
    logic [CNT_W-1:0]  frame_cnt;

    int n_vec = 0;
    int n_err = 0;

    tpg_timing_ctrl #(.H_BITS(H_BITS), .V_BITS(V_BITS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_commit(cfg_commit), .start(start), .stop(stop), .sof(sof),
        .run_en(run_en),
        .tHS_START(tHS_START), .tHS_END(tHS_END), .tHACT_START(tHACT_START),
        .tHACT_END(tHACT_END), .tH_END(tH_END),
        .tVS_START(tVS_START), .tVS_END(tVS_END), .tVACT_START(tVACT_START),
        .tVACT_END(tVACT_END), .tV_END(tV_END),
        .mode_valid(mode_valid), .mode_applied(mode_applied),
        .commit_pending(commit_pending), .cfg_err(cfg_err),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic pulse_sof();
        sof = 1'b1;
        tick();
        sof = 1'b0;
    endtask

    // Expected active set after the first commit.
    logic [15:0] init_vals [10] = '{16'd10, 16'd20, 16'd30, 16'd200, 16'd220,
                                    16'd1, 16'd3, 16'd5, 16'd100, 16'd110};

    initial begin
        // ---------------- reset ----------------
        repeat (3) tick();
        check_val("rst_run_en", run_en, 0);
        check_val("rst_mode_valid", mode_valid, 0);
        check_val("rst_pending", commit_pending, 0);
        check_val("rst_tH_END", tH_END, 0);
        check_val("rst_frame_cnt", frame_cnt, 0);
        rst_n = 1'b1;
        tick();

        // ---------------- load shadow ----------------
        for (int i = 0; i < 10; i++) wr(i[3:0], init_vals[i]);

        // start without a valid mode is ignored
        start = 1'b1; tick(); start = 1'b0; tick();
        check_val("start_no_mode", run_en, 0);
        check_val("no_mode_applied", tHS_START, 0);

        // commit in IDLE
        cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
        check_val("idle_applied", mode_applied, 1);
        check_val("idle_valid", mode_valid, 1);
        check_val("idle_pending", commit_pending, 0);
        check_val("tHS_START", tHS_START, 10);
        check_val("tHS_END", tHS_END, 20);
        check_val("tHACT_START", tHACT_START, 30);
        check_val("tHACT_END", tHACT_END, 200);
        check_val("tH_END", tH_END, 220);
        check_val("tVS_START", tVS_START, 1);
        check_val("tVS_END", tVS_END, 3);
        check_val("tVACT_START", tVACT_START, 5);
        check_val("tVACT_END", tVACT_END, 100);
        check_val("tV_END", tV_END, 110);
        tick();
        check_val("idle_applied_1cyc", mode_applied, 0);

        // ---------------- start ----------------
        start = 1'b1; tick(); start = 1'b0;
        check_val("start_run_en", run_en, 1);
        check_val("start_frame_cnt", frame_cnt, 0);

        // deferred commit in RUN
        wr(4'd4, 16'd300);
        cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
        check_val("run_pending", commit_pending, 1);
        check_val("run_no_applied", mode_applied, 0);
        for (int i = 0; i < 50; i++) begin
            tick();
            if (i % 10 == 0) begin
                check_val("wait_pending", commit_pending, 1);
                check_val("wait_tH_END", tH_END, 220);
            end
        end
        pulse_sof();
        check_val("sof_tH_END", tH_END, 300);
        check_val("sof_applied", mode_applied, 1);
        check_val("sof_pending_clr", commit_pending, 0);
        check_val("sof_frame_cnt", frame_cnt, 1);
        tick();
        check_val("sof_applied_1cyc", mode_applied, 0);

        // ---------------- stop mid-frame ----------------
        stop = 1'b1; tick(); stop = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i % 8 == 0) check_val("stopping_run_en", run_en, 1);
            tick();
        end
        check_val("stopping_run_en_end", run_en, 1);
        pulse_sof();
        check_val("stop_run_en", run_en, 0);
        check_val("stop_frame_hold", frame_cnt, 1);

        // ---------------- frame limit ----------------
        wr(4'd10, 16'd3);
        start = 1'b1; tick(); start = 1'b0;
        check_val("lim_start_cnt", frame_cnt, 0);
        for (int f = 1; f <= 3; f++) begin
            repeat (5) tick();
            pulse_sof();
            check_val("lim_cnt", frame_cnt, f);
            check_val("lim_run_en", run_en, 1);
        end
        // start while STOPPING must not restart the run
        start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        pulse_sof();
        check_val("lim_run_en_off", run_en, 0);
        check_val("lim_cnt_hold", frame_cnt, 3);

        // ---------------- start+stop together ----------------
        wr(4'd10, 16'd0);
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        tick();
        check_val("ss_idle", run_en, 0);
        start = 1'b1; tick(); start = 1'b0;
        check_val("ss_run", run_en, 1);
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        pulse_sof();
        check_val("ss_stopped", run_en, 0);
        check_val("ss_cnt", frame_cnt, 0);

        // ---------------- commit and sof same cycle ----------------
        start = 1'b1; tick(); start = 1'b0;
        wr(4'd4, 16'd400);
        cfg_commit = 1'b1; sof = 1'b1; tick(); cfg_commit = 1'b0; sof = 1'b0;
        check_val("cs_tH_END", tH_END, 400);
        check_val("cs_pending", commit_pending, 0);
        check_val("cs_applied", mode_applied, 1);

        // repeat commit while pending takes latest shadow
        wr(4'd4, 16'd500);
        cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
        wr(4'd4, 16'd650);
        cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
        check_val("rep_pending", commit_pending, 1);
        // write landing in the sof cycle is not part of the apply
        sof = 1'b1; cfg_wr = 1'b1; cfg_addr = 4'd4; cfg_wdata = 16'd700;
        tick();
        sof = 1'b0; cfg_wr = 1'b0;
        check_val("rep_tH_END", tH_END, 650);
        check_val("rep_pending_clr", commit_pending, 0);

        // pending commit applied at the stopping sof
        stop = 1'b1; tick(); stop = 1'b0;
        cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
        check_val("stp_pending", commit_pending, 1);
        pulse_sof();
        check_val("stp_tH_END", tH_END, 700);
        check_val("stp_run_en", run_en, 0);

        // ---------------- timing check ----------------
        wr(4'd1, 16'd5);
        cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
`ifdef TPG_TIMING_CHECK_EN
        check_val("chk_err", cfg_err, 1);
        check_val("chk_tHS_END", tHS_END, 20);
        check_val("chk_applied", mode_applied, 0);
        check_val("chk_pending", commit_pending, 0);
        tick();
        check_val("chk_err_1cyc", cfg_err, 0);
`else
        check_val("chk_err", cfg_err, 0);
        check_val("chk_tHS_END", tHS_END, 5);
        check_val("chk_applied", mode_applied, 1);
        check_val("chk_pending", commit_pending, 0);
`endif

        // ---------------- asynchronous reset while running ----------------
        wr(4'd1, 16'd20);
        start = 1'b1; tick(); start = 1'b0;
        check_val("ar_run_en", run_en, 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("ar_run_en_drop", run_en, 0);
        check_val("ar_tH_END", tH_END, 0);
        check_val("ar_mode_valid", mode_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tpg_timing_ctrl.md
Name: tpg_timing_ctrl

Overview:
- Timing/run controller in front of the test pattern generator.
- Holds a shadow set and an active set of video timing registers, written over a simple register-write port.
- Applies committed timing changes only at frame boundaries (sof pulse from the generator) while running.
- Sequences generator enable (start/stop/frame-limit auto-stop), always stopping on a frame boundary.

Parameters:
H_BITS, 12, width of horizontal timing values
V_BITS, 12, width of vertical timing values
CNT_W, 16, width of frame counter and frame limit

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_wr  in  1  register write strobe, one cycle per write
cfg_addr  in  4  register address: 0 HS_START, 1 HS_END, 2 HACT_START, 3 HACT_END, 4 H_END, 5 VS_START, 6 VS_END, 7 VACT_START, 8 VACT_END, 9 V_END, 10 FRAME_LIMIT; 11-15 ignored
cfg_wdata  in  16  write data; low H_BITS/V_BITS/CNT_W bits used
cfg_commit  in  1  request shadow->active transfer
start  in  1  start pulse
stop  in  1  stop pulse
sof  in  1  start-of-frame pulse from generator
run_en  out  1  generator enable
tHS_START, tHS_END, tHACT_START, tHACT_END, tH_END  out  H_BITS each  active horizontal timing
tVS_START, tVS_END, tVACT_START, tVACT_END, tV_END  out  V_BITS each  active vertical timing
mode_valid  out  1  at least one mode applied since reset
mode_applied  out  1  one-cycle pulse when active set updated
commit_pending  out  1  commit accepted, waiting for sof
cfg_err  out  1  one-cycle pulse, commit rejected
frame_cnt  out  CNT_W  frames started since last start

Behaviour:
- Reset: all shadow/active regs, FRAME_LIMIT, frame_cnt = 0; run_en, mode_valid, mode_applied, commit_pending, cfg_err = 0; state IDLE.
- Writes: addr 0-9 update shadow only, visible in shadow next cycle. Addr 10 updates FRAME_LIMIT directly. 0 = unlimited.
- Apply semantics: shadow value sampled at the apply edge. A same-cycle cfg_wr lands in shadow but is not part of that apply.
- FSM states: IDLE, RUN, STOPPING.
- IDLE:
  - run_en=0.
  - cfg_commit accepted: active<=shadow next edge, mode_applied pulse, mode_valid<=1, no pending.
  - start with mode_valid=1: RUN, run_en=1 next cycle, frame_cnt<=0.
  - start with mode_valid=0: ignored.
  - stop and sof: ignored.
- RUN:
  - run_en=1.
  - Accepted cfg_commit: commit_pending<=1.
  - sof: frame_cnt+1 (saturates at all-ones). If commit_pending, apply shadow->active, pulse mode_applied, clear pending.
  - cfg_commit and sof in the same cycle: apply immediately at that sof; pending ends 0.
  - stop: STOPPING.
  - sof with FRAME_LIMIT!=0 and frame_cnt+1 == FRAME_LIMIT: STOPPING.
- STOPPING:
  - run_en stays 1 until next sof.
  - On that sof: run_en<=0, IDLE. frame_cnt not incremented. Any pending commit is applied at this sof.
  - start in STOPPING: ignored.
  - New commits still pend.
- start and stop in the same cycle: stop wins, so IDLE stays IDLE and RUN goes to STOPPING.
- Repeat commit while pending: stays pending; the apply takes the latest shadow.
- Latency: start->run_en 1 cycle. sof->active update 1 cycle (visible on outputs the cycle after sof).
- Reset mid-frame: immediate return to reset values, run_en drops asynchronously.

Optional Feature:
- Macro: TPG_TIMING_CHECK_EN.
- Compiled in, a commit is rejected (cfg_err pulse, no apply, pending unchanged) unless all of the following hold on the shadow values:
  - HS_START < HS_END <= H_END
  - HACT_START < HACT_END <= H_END
  - VS_START < VS_END <= V_END
  - VACT_START < VACT_END <= V_END
- Compiled out: every commit is accepted and cfg_err is tied 0.

Test Plan:
- Reset, write addr0-9 = 10,20,30,200,220,1,3,5,100,110, commit in IDLE -> mode_applied pulse next cycle, outputs equal written values, mode_valid=1.
- start before any commit -> run_en stays 0. Commit, then start -> run_en=1 one cycle after start, frame_cnt=0.
- In RUN, write H_END=300, commit, 50 cycles later sof -> commit_pending=1 until sof, tH_END=220 until sof, 300 the cycle after; mode_applied a single pulse.
- FRAME_LIMIT=3, start, issue 4 sofs -> frame_cnt 1,2,3, STOPPING after 3rd, run_en=0 after 4th sof, frame_cnt holds 3.
- stop mid-frame then sof 40 cycles later -> run_en remains 1 for those 40 cycles, falls after sof. start+stop same cycle in RUN -> STOPPING.
- TPG_TIMING_CHECK_EN: shadow HS_END=5 < HS_START=10, commit -> cfg_err pulse, active unchanged, commit_pending=0. Without macro -> applied.
